// File: rtl/apb_cfg_master.sv
// apb_cfg_master: APB requester driving the TPU configuration register slave.
// Define CFG_MASTER_DONE_POLL_EN to build read-until-done polling commands.
module apb_cfg_master #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int POLL_BIT       = 31,
   parameter int POLL_LIMIT     = 1024
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic              cmd_poll,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t            state, state_n;
   logic [TW-1:0]     tmo, tmo_n;
   logic [ADDR_W-1:0] paddr_n;
   logic [DATA_W-1:0] pwdata_n, rdata_n;
   logic              pwrite_n, psel_n, penable_n;
   logic              rsp_valid_n, rsp_err_n;

`ifdef CFG_MASTER_DONE_POLL_EN
   localparam int PW = $clog2(POLL_LIMIT + 1);
   logic          poll, poll_n, again, again_n;
   logic [PW-1:0] pcnt, pcnt_n;
`else
   localparam int unused_cfg = POLL_BIT + POLL_LIMIT;
   logic unused_poll;
   assign unused_poll = cmd_poll;
`endif

   assign cmd_ready = PRESETn && (state == IDLE);
   assign busy      = (state != IDLE);

   always_comb begin
      state_n     = state;
      tmo_n       = tmo;
      paddr_n     = PADDR;
      pwdata_n    = PWDATA;
      pwrite_n    = PWRITE;
      psel_n      = 1'b0;
      penable_n   = 1'b0;
      rsp_valid_n = 1'b0;
      rsp_err_n   = 1'b0;
      rdata_n     = '0;
`ifdef CFG_MASTER_DONE_POLL_EN
      poll_n  = poll;
      again_n = 1'b0;
      pcnt_n  = pcnt;
`endif
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_n  = SETUP;
               psel_n   = 1'b1;
               paddr_n  = cmd_addr;
               pwdata_n = cmd_wdata;
               pwrite_n = cmd_write;
`ifdef CFG_MASTER_DONE_POLL_EN
               poll_n = cmd_poll & ~cmd_write;
               pcnt_n = '0;
`endif
            end
         end
         SETUP: begin
            state_n   = ACCESS;
            psel_n    = 1'b1;
            penable_n = 1'b1;
            tmo_n     = '0;
         end
         ACCESS: begin
            psel_n    = 1'b1;
            penable_n = 1'b1;
            if (PREADY) begin
               state_n     = GAP;
               psel_n      = 1'b0;
               penable_n   = 1'b0;
               rsp_valid_n = 1'b1;
               rdata_n     = PWRITE ? '0 : PRDATA;
`ifdef CFG_MASTER_DONE_POLL_EN
               // done bit still clear: retry silently until the read budget runs out
               if (poll && !PRDATA[POLL_BIT]) begin
                  if (pcnt == PW'(POLL_LIMIT - 1)) begin
                     rsp_err_n = 1'b1;
                  end else begin
                     rsp_valid_n = 1'b0;
                     rdata_n     = '0;
                     again_n     = 1'b1;
                     pcnt_n      = pcnt + PW'(1);
                  end
               end
`endif
            end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
               state_n     = GAP;
               psel_n      = 1'b0;
               penable_n   = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b1;
            end else begin
               tmo_n = tmo + TW'(1);
            end
         end
         GAP: begin
            state_n = IDLE;
`ifdef CFG_MASTER_DONE_POLL_EN
            if (again) begin
               state_n = SETUP;
               psel_n  = 1'b1;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         tmo       <= '0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PWRITE    <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_n;
         tmo       <= tmo_n;
         PADDR     <= paddr_n;
         PWDATA    <= pwdata_n;
         PWRITE    <= pwrite_n;
         PSEL      <= psel_n;
         PENABLE   <= penable_n;
         rsp_valid <= rsp_valid_n;
         rsp_err   <= rsp_err_n;
         rsp_rdata <= rdata_n;
      end
   end

`ifdef CFG_MASTER_DONE_POLL_EN
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         poll  <= 1'b0;
         again <= 1'b0;
         pcnt  <= '0;
      end else begin
         poll  <= poll_n;
         again <= again_n;
         pcnt  <= pcnt_n;
      end
   end
`endif

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master: table vectors, random commands vs a register-array model,
// and hand sequences for back-to-back, timeout, async reset and polling.
module tb_apb_cfg_master;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic          cmd_poll = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          busy;
   logic [AW-1:0] PADDR;
   logic          PWRITE, PSEL, PENABLE;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA = '0;
   logic          PREADY = 1'b0;

   always #5 PCLK = ~PCLK;

   apb_cfg_master #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16),
      .POLL_BIT(31), .POLL_LIMIT(1024)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_poll(cmd_poll),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
      .PENABLE(PENABLE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );

   int tests = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // slave model: PREADY comes swait edges after PENABLE is seen
   logic [31:0] smem [256] = '{default: 32'h0};
   int swait = 0;
   bit stuck = 1'b0;
   bit poll_mode = 1'b0;
   int poll_total = 0;
   int poll_base = 0;
   int poll_rise = 0;
   int wcnt = 0;

   function automatic logic [31:0] rdval(input logic [7:0] a);
      logic [31:0] v;
      v = smem[a];
      if (poll_mode && a == 8'h04 && (poll_total - poll_base) >= poll_rise)
         v[31] = 1'b1;
      return v;
   endfunction

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PREADY <= 1'b0;
         wcnt   <= 0;
      end else if (PSEL && PENABLE) begin
         if (PREADY) begin
            if (PWRITE) smem[PADDR] <= PWDATA;
            else if (PADDR == 8'h04) poll_total <= poll_total + 1;
            PREADY <= 1'b0;
            wcnt   <= 0;
            PRDATA <= $urandom;
         end else if (!stuck && wcnt >= swait) begin
            PREADY <= 1'b1;
            PRDATA <= rdval(PADDR);
         end else begin
            wcnt   <= wcnt + 1;
            PRDATA <= $urandom;
         end
      end else begin
         PREADY <= 1'b0;
         wcnt   <= 0;
         PRDATA <= $urandom;
      end
   end

   // bus protocol monitor
   bit          rsp_expected = 1'b0;
   bit          bus_chk = 1'b1;
   bit          cur_write = 1'b0;
   logic [7:0]  cur_addr = '0;
   logic [31:0] cur_wdata = '0;
   int          psel_rises = 0;
   logic        prev_psel = 1'b0;
   logic        prev_pen = 1'b0;
   logic        prev_rsp = 1'b0;
   logic [40:0] prev_bus = '0;

   always @(negedge PCLK) begin
      if (PRESETn) begin
         chk("ready_xor_busy", cmd_ready ^ busy, 1);
         chk("rsp_with_psel", rsp_valid & PSEL, 0);
         chk("rsp_pulse", rsp_valid & prev_rsp, 0);
         if (rsp_valid) chk("spurious_rsp", rsp_valid, rsp_expected);
         if (PENABLE) begin
            chk("penable_psel", PSEL, 1);
            if (!prev_pen) chk("setup_phase", {prev_psel, prev_pen}, 2'b10);
         end
         if (PSEL) begin
            chk("pwrite", PWRITE, cur_write);
            if (bus_chk) begin
               chk("paddr", PADDR, cur_addr);
               if (cur_write) chk("pwdata", PWDATA, cur_wdata);
            end
            if (prev_psel) chk("apb_hold", {PADDR, PWRITE, PWDATA}, prev_bus);
            else psel_rises <= psel_rises + 1;
         end
      end
      prev_psel <= PSEL;
      prev_pen  <= PENABLE;
      prev_rsp  <= rsp_valid;
      prev_bus  <= {PADDR, PWRITE, PWDATA};
   end

   task automatic do_cmd(input bit w, input logic [7:0] a, input logic [31:0] d,
                         input bit p, output logic [31:0] rd, output bit er,
                         output int lat);
      int n;
      n = 0;
      cur_write = w;
      cur_addr = a;
      cur_wdata = d;
      rsp_expected = 1'b1;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr = a;
      cmd_wdata = d;
      cmd_poll = p;
      while (!cmd_ready && n < 50) begin
         @(posedge PCLK); #1;
         n++;
      end
      chk("accept_wait", cmd_ready, 1);
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      cmd_poll = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 5000) begin
         @(posedge PCLK); #1;
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge PCLK); #1;
      rsp_expected = 1'b0;
   endtask

   typedef struct {
      bit          w;
      logic [7:0]  a;
      logic [31:0] d;
      int          wt;
      bit          st;
      logic [31:0] rdata;
      bit          err;
      int          lat;
   } vec_t;

   vec_t        tbl [10];
   logic [31:0] ref_mem [256];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      bit          er;
      int          lat;
      int          r0;

      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

      // lat counts cycles from the accept edge to the visible rsp_valid;
      // each PREADY-low ACCESS edge uses one timeout step (16 allowed)
      tbl[0] = '{1'b1, 8'h04, 32'h0000_0001, 0,  1'b0, 32'h0,         1'b0, 4};
      tbl[1] = '{1'b0, 8'h04, 32'h0,         0,  1'b0, 32'h0000_0001, 1'b0, 4};
      tbl[2] = '{1'b1, 8'h08, 32'hA5A5_5A5A, 2,  1'b0, 32'h0,         1'b0, 6};
      tbl[3] = '{1'b0, 8'h08, 32'h0,         1,  1'b0, 32'hA5A5_5A5A, 1'b0, 5};
      tbl[4] = '{1'b0, 8'h10, 32'h0,         0,  1'b0, 32'h0,         1'b0, 4};
      tbl[5] = '{1'b1, 8'hFC, 32'hFFFF_FFFF, 14, 1'b0, 32'h0,         1'b0, 18};
      tbl[6] = '{1'b0, 8'hFC, 32'h0,         0,  1'b0, 32'hFFFF_FFFF, 1'b0, 4};
      tbl[7] = '{1'b0, 8'h04, 32'h0,         0,  1'b1, 32'h0,         1'b1, 18};
      tbl[8] = '{1'b1, 8'h04, 32'h0000_DEAD, 15, 1'b0, 32'h0,         1'b1, 18};
      tbl[9] = '{1'b0, 8'h04, 32'h0,         0,  1'b0, 32'h0000_0001, 1'b0, 4};

      // reset state, with a command already waiting
      cmd_valid = 1'b1;
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      PRESETn = 1'b1;
      cmd_valid = 1'b0;
      @(posedge PCLK); #1;
      chk("ready_after_rst", cmd_ready, 1);

      for (int i = 0; i < 10; i++) begin
         swait = tbl[i].wt;
         stuck = tbl[i].st;
         do_cmd(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
         chk($sformatf("vec%0d_err", i), er, tbl[i].err);
         chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
         if (tbl[i].w && !tbl[i].err) ref_mem[tbl[i].a] = tbl[i].d;
      end
      stuck = 1'b0;

      // back-to-back: cmd_valid held across two writes
      begin
         bit ps [16];
         int rv, acc0, acc1, gap, s0;
         bit acc;
         rv = 0; acc0 = -1; acc1 = -1;
         swait = 0;
         cur_write = 1'b1;
         bus_chk = 1'b0;
         rsp_expected = 1'b1;
         cmd_valid = 1'b1;
         cmd_write = 1'b1;
         cmd_addr = 8'h20;
         cmd_wdata = 32'h1111_2222;
         for (int s = 0; s < 16; s++) begin
            ps[s] = PSEL;
            if (rsp_valid) rv++;
            acc = cmd_valid && cmd_ready;
            if (acc) begin
               if (acc0 < 0) acc0 = s;
               else acc1 = s;
            end
            @(posedge PCLK); #1;
            if (acc && acc1 < 0) begin
               cmd_addr = 8'h24;
               cmd_wdata = 32'h3333_4444;
            end else if (acc) begin
               cmd_valid = 1'b0;
            end
         end
         chk("b2b_first_accept", acc0, 0);
         chk("b2b_spacing", acc1 - acc0, 5);
         chk("b2b_rsp_count", rv, 2);
         s0 = 0;
         while (s0 < 15 && !ps[s0]) s0++;
         while (s0 < 15 && ps[s0]) s0++;
         gap = 0;
         while (s0 < 15 && !ps[s0]) begin
            gap++;
            s0++;
         end
         // setup plus two access cycles in a 5-cycle slot leave 2 idle-bus cycles
         chk("b2b_psel_low", gap, 5 - 3);
         rsp_expected = 1'b0;
         bus_chk = 1'b1;
         ref_mem[8'h20] = 32'h1111_2222;
         ref_mem[8'h24] = 32'h3333_4444;
         do_cmd(1'b0, 8'h20, 32'h0, 1'b0, rd, er, lat);
         chk("b2b_rd0", rd, ref_mem[8'h20]);
         do_cmd(1'b0, 8'h24, 32'h0, 1'b0, rd, er, lat);
         chk("b2b_rd1", rd, ref_mem[8'h24]);
      end

      // random commands against the register-array model
      for (int i = 0; i < 60; i++) begin
         bit          w, st;
         logic [7:0]  a;
         logic [31:0] d, e_rd;
         int          wt, e_lat;
         bit          e_er;
         w = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 15) * 4);
         d = $urandom;
         wt = $urandom_range(0, 3);
         st = ($urandom_range(0, 9) == 0);
         swait = wt;
         stuck = st;
         if (st) begin
            e_rd = 32'h0; e_er = 1'b1; e_lat = 18;
         end else if (w) begin
            e_rd = 32'h0; e_er = 1'b0; e_lat = 4 + wt;
            ref_mem[a] = d;
         end else begin
            e_rd = ref_mem[a]; e_er = 1'b0; e_lat = 4 + wt;
         end
         do_cmd(w, a, d, 1'b0, rd, er, lat);
         chk("rnd_rdata", rd, e_rd);
         chk("rnd_err", er, e_er);
         chk("rnd_lat", lat, e_lat);
      end
      stuck = 1'b0;
      swait = 0;

      // asynchronous reset in the middle of an ACCESS phase
      stuck = 1'b1;
      cur_write = 1'b0;
      cur_addr = 8'h04;
      cmd_write = 1'b0;
      cmd_addr = 8'h04;
      cmd_valid = 1'b1;
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      chk("rst_pre_access", {PSEL, PENABLE}, 2'b11);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("arst_psel", PSEL, 0);
      chk("arst_penable", PENABLE, 0);
      chk("arst_rsp", rsp_valid, 0);
      chk("arst_ready", cmd_ready, 0);
      chk("arst_busy", busy, 0);
      repeat (2) @(posedge PCLK);
      #1;
      PRESETn = 1'b1;
      stuck = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      do_cmd(1'b0, 8'h04, 32'h0, 1'b0, rd, er, lat);
      chk("post_rst_rdata", rd, ref_mem[8'h04]);
      chk("post_rst_lat", lat, 4);

`ifdef CFG_MASTER_DONE_POLL_EN
      poll_mode = 1'b1;
      poll_base = poll_total;
      poll_rise = 3;
      r0 = psel_rises;
      do_cmd(1'b0, 8'h04, 32'h0, 1'b1, rd, er, lat);
      chk("poll_rdata", rd, ref_mem[8'h04] | 32'h8000_0000);
      chk("poll_err", er, 0);
      chk("poll_reads", psel_rises - r0, 4);
      chk("poll_lat", lat, 16);

      poll_base = poll_total;
      poll_rise = 100000;
      r0 = psel_rises;
      do_cmd(1'b0, 8'h04, 32'h0, 1'b1, rd, er, lat);
      chk("plim_rdata", rd, ref_mem[8'h04]);
      chk("plim_err", er, 1);
      chk("plim_reads", psel_rises - r0, 1024);
      chk("plim_lat", lat, 4 * 1024);

      stuck = 1'b1;
      do_cmd(1'b0, 8'h04, 32'h0, 1'b1, rd, er, lat);
      chk("ptmo_rdata", rd, 0);
      chk("ptmo_err", er, 1);
      chk("ptmo_lat", lat, 18);
      stuck = 1'b0;

      r0 = psel_rises;
      do_cmd(1'b1, 8'h30, 32'h0BAD_F00D, 1'b1, rd, er, lat);
      ref_mem[8'h30] = 32'h0BAD_F00D;
      chk("pwr_err", er, 0);
      chk("pwr_lat", lat, 4);
      chk("pwr_reads", psel_rises - r0, 1);
      poll_mode = 1'b0;
`else
      r0 = psel_rises;
      do_cmd(1'b0, 8'h04, 32'h0, 1'b1, rd, er, lat);
      chk("nopoll_rdata", rd, ref_mem[8'h04]);
      chk("nopoll_err", er, 0);
      chk("nopoll_lat", lat, 4);
      chk("nopoll_reads", psel_rises - r0, 1);
`endif

      repeat (3) @(posedge PCLK);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
